// File: rtl/instr_loader_if.sv
// Host byte link, instruction-memory write port and core-control lines of instr_loader.
interface instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_err
  );
endinterface

// File: rtl/instr_loader.sv
// Byte-serial program loader: assembles big-endian words into instruction memory and holds the core in reset until done.
// Optional trailing XOR checksum byte enabled with `define LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input logic            clk,
  input logic            rst,
  instr_loader_if.slave  bus
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd4,
    S_ERROR = 3'd6,
`endif
    S_DONE  = 3'd5
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  state_t            state_r;
  state_t            state_s;
  logic              ready_s;
  logic              byte_ok_s;
  logic [CNT_W-1:0]  word_next_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  word_idx_r;
  logic [1:0]        byte_idx_r;
  logic [23:0]       shift_r;
  logic              in_ready_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              core_hold_r;
  logic              load_done_r;

  assign byte_ok_s   = bus.in_valid && in_ready_r;
  assign word_next_s = word_idx_r + CNT_W'(1);

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign bus.core_hold  = core_hold_r;
  assign bus.load_done  = load_done_r;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_r;
  logic       load_err_r;
  assign bus.load_err = load_err_r;
`else
  assign bus.load_err = 1'b0;
`endif

  // Next-state logic; start is only honoured in IDLE, DONE and ERROR.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_s = S_COUNT;
        else           state_s = S_IDLE;
      end
      S_COUNT: begin
        if (byte_ok_s) state_s = S_DATA;
        else           state_s = S_COUNT;
      end
      S_DATA: begin
        if (byte_ok_s && (byte_idx_r == 2'd3)) state_s = S_WRITE;
        else                                   state_s = S_DATA;
      end
      S_WRITE: begin
        if (word_next_s != count_r) state_s = S_DATA;
`ifdef LOADER_CHECKSUM_EN
        else                        state_s = S_CHECK;
`else
        else                        state_s = S_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_ok_s) begin
          if (bus.in_data == xor_r) state_s = S_DONE;
          else                      state_s = S_ERROR;
        end else begin
          state_s = S_CHECK;
        end
      end
      S_ERROR: begin
        if (bus.start) state_s = S_COUNT;
        else           state_s = S_ERROR;
      end
`endif
      S_DONE: begin
        if (bus.start) state_s = S_COUNT;
        else           state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Byte acceptance window follows the state being entered.
  always_comb begin
    ready_s = 1'b0;
    case (state_s)
      S_COUNT: ready_s = 1'b1;
      S_DATA:  ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: ready_s = 1'b1;
`endif
      default: ready_s = 1'b0;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b0;
      imem_we_r   <= 1'b0;
      core_hold_r <= 1'b1;
      load_done_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      load_err_r  <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      in_ready_r  <= ready_s;
      imem_we_r   <= (state_s == S_WRITE);
      core_hold_r <= (state_s != S_DONE);
      load_done_r <= (state_s == S_DONE);
`ifdef LOADER_CHECKSUM_EN
      load_err_r  <= (state_s == S_ERROR);
`endif
    end
  end

  // Word assembly, counters and the write-port address/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r      <= '0;
      word_idx_r   <= '0;
      byte_idx_r   <= 2'd0;
      shift_r      <= 24'd0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_r        <= 8'd0;
`endif
    end else if ((state_s == S_COUNT) && (state_r != S_COUNT)) begin
      word_idx_r <= '0;
      byte_idx_r <= 2'd0;
      shift_r    <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_r      <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_COUNT: begin
          // A zero count byte means a full 2^ADDR_W-word image.
          if (byte_ok_s) begin
            if (bus.in_data == 8'd0) count_r <= CNT_W'(1) << ADDR_W;
            else                     count_r <= CNT_W'(bus.in_data);
          end
        end
        S_DATA: begin
          if (byte_ok_s) begin
            shift_r    <= {shift_r[15:0], bus.in_data};
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_r      <= xor_fold(xor_r, bus.in_data);
`endif
            if (byte_idx_r == 2'd3) begin
              imem_wdata_r <= {shift_r, bus.in_data};
              imem_addr_r  <= ADDR_W'(BASE_ADDR) + word_idx_r[ADDR_W-1:0];
            end
          end
        end
        S_WRITE: word_idx_r <= word_next_s;
        default: word_idx_r <= word_idx_r;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: two instances (BASE_ADDR 0 and 250) fed the same byte stream.
module tb_instr_loader;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(8)) bus0 ();
  instr_loader_if #(.ADDR_W(8)) bus1 ();

  assign bus0.start    = start;
  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus1.start    = start;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;

  instr_loader #(.ADDR_W(8), .BASE_ADDR(0))   dut0 (.clk(clk), .rst(rst), .bus(bus0));
  instr_loader #(.ADDR_W(8), .BASE_ADDR(250)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          n;
    logic [31:0] seed;
    bit          gap;
    bit          bad;
    bit          exp_hold;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t  q0[$];
  wr_t  q1[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_we_cyc = -1;
  int   acc_cyc = -1;
  int   end_cyc;
  int   ref_cyc;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the BASE_ADDR=0 instance; write cycles must never show done or a released core.
  always @(negedge clk) begin
    wr_t e;
    if (bus0.imem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (q0.size() == 0) begin
        check("dut0_unexpected_write", {24'd0, bus0.imem_addr, bus0.imem_wdata}, 64'd0);
      end else begin
        e = q0.pop_front();
        check("dut0_write", {21'd0, bus0.imem_addr, bus0.imem_wdata, bus0.load_done, bus0.core_hold, bus0.in_ready},
              {21'd0, e.addr, e.data, 1'b0, 1'b1, 1'b0});
      end
    end
  end

  // Scoreboard for the BASE_ADDR=250 instance (address wrap).
  always @(negedge clk) begin
    wr_t e;
    if (bus1.imem_we === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_write", {24'd0, bus1.imem_addr, bus1.imem_wdata}, 64'd0);
      end else begin
        e = q1.pop_front();
        check("dut1_write", {24'd0, bus1.imem_addr, bus1.imem_wdata}, {24'd0, e.addr, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      if (bus0.in_ready === 1'b1) begin
        acc     = 1'b1;
        acc_cyc = cyc;
      end
      tick();
    end
    if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic load_image(input int n, input logic [31:0] seed, input bit gap, input bit bad);
    logic [7:0]  ck;
    logic [7:0]  b;
    logic [31:0] w;
    ck = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(n[7:0], gap);
    for (int i = 0; i < n; i++) begin
      w = seed ^ (i * 32'h01030507);
      q0.push_back('{addr: 8'(i), data: w});
      q1.push_back('{addr: 8'(250 + i), data: w});
      for (int j = 0; j < 4; j++) begin
        b  = w[31 - 8 * j -: 8];
        ck = ck ^ b;
        send_byte(b, gap && (j != 3));
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad ? (ck ^ 8'h07) : ck, 1'b0);
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_end(output int c);
    bit seen = 1'b0;
    c = -1;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus0.load_done === 1'b1 || bus0.load_err === 1'b1) begin
        seen = 1'b1;
        c    = cyc;
      end
    end
    if (!seen) check("end_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;

    vecs[0] = '{1,   32'h2001000A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3,   32'hA5C30F11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{10,  32'h13572468, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1,   32'h2001000A, 1'b0, 1'b1, CK,   !CK,  CK};
    vecs[4] = '{4,   32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{256, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset for two cycles, with start raised in the second: reset wins.
    tick();
    start = 1'b1;
    tick();
    @(negedge clk);
    check("reset_state", {bus0.core_hold, bus0.in_ready, bus0.imem_we, bus0.load_done, bus0.load_err,
                          bus0.imem_addr, bus0.imem_wdata}, {1'b1, 4'b0000, 8'd0, 32'd0});
    rst   = 1'b0;
    start = 1'b0;
    tick();
    @(negedge clk);
    check("idle_after_reset", {bus0.core_hold, bus0.in_ready, bus0.load_done}, 3'b100);
    tick();

    for (int k = 0; k < 6; k++) begin
      load_image(vecs[k].n, vecs[k].seed, vecs[k].gap, vecs[k].bad);
      wait_end(end_cyc);
      check($sformatf("row%0d_status", k),
            {bus0.core_hold, bus0.load_done, bus0.load_err, bus0.in_ready, bus0.imem_we},
            {vecs[k].exp_hold, vecs[k].exp_done, vecs[k].exp_err, 2'b00});
      ref_cyc = CK ? acc_cyc + 1 : last_we_cyc + 1;
      check($sformatf("row%0d_done_timing", k), 64'(end_cyc), 64'(ref_cyc));
      check($sformatf("row%0d_all_written", k), 64'(q0.size() + q1.size()), 64'd0);
      tick();
    end

    // Start in DONE re-asserts core_hold on the next cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_in_done", {bus0.core_hold, bus0.load_done, bus0.in_ready}, 3'b101);
    tick();

    // Reset after two bytes of word 1 aborts: word 0 written, nothing more.
    send_byte(8'd2, 1'b0);
    q0.push_back('{addr: 8'd0, data: 32'hCAFE0123});
    q1.push_back('{addr: 8'd250, data: 32'hCAFE0123});
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", {bus0.core_hold, bus0.in_ready, bus0.imem_we, bus0.load_done}, 4'b1000);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (10) tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_no_writes", {32'(q0.size()), 31'd0, bus0.in_ready}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-serial program loader that writes 32-bit instruction words into the instruction memory read by the instruction fetch stage. It holds the processor core in reset while loading and releases it once the image is complete. It sits between a host byte link (UART/JTAG bridge or testbench) and the write port of the instruction memory. It is the write side of the memory that instruction fetch reads.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; matches the fetch stage's 8-bit PC.
- BASE_ADDR, 0, word address of the first loaded instruction.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word write address.
- imem_wdata  out  32  instruction word.
- core_hold  out  1  drives the core's rst; high while no valid image is present.
- load_done  out  1  level; image loaded and core released.
- load_err  out  1  level; checksum mismatch.

## Operation
- A byte is accepted only when in_valid && in_ready. in_valid with in_ready low is ignored, and the host must hold the byte.
- States:
  - IDLE: core_hold=1. start -> COUNT.
  - COUNT: in_ready=1. The accepted byte is N, the word count, latched into a 9-bit count. N=0 means 2^ADDR_W words (256 at default). -> DATA with word index 0 and byte index 0.
  - DATA: in_ready=1. Bytes are big-endian: the first byte goes to [31:24] and the fourth to [7:0]. The 4th accepted byte -> WRITE.
  - WRITE: in_ready=0. imem_we=1, imem_addr=(BASE_ADDR+index) mod 2^ADDR_W, imem_wdata=assembled word.
    - Word index increments.
    - If words remain -> DATA.
    - Else -> CHECK (macro on) or DONE.
  - CHECK: in_ready=1. The accepted byte is compared with the running XOR of all data bytes. Equal -> DONE, else -> ERROR.
  - DONE: core_hold=0, load_done=1. start -> COUNT, with core_hold=1 and load_done=0 from the next cycle.
  - ERROR: core_hold=1, load_err=1. start -> COUNT and clears load_err.
- start is ignored in COUNT, DATA, WRITE and CHECK.
- The byte assembler and XOR accumulator are cleared on every entry to COUNT.

## Timing
- Reset values: state IDLE; core_hold=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; load_done=0; load_err=0.
- rst mid-load aborts immediately. Words already written stay in memory, and the loader returns to IDLE with core_hold=1.
- Byte acceptance is single-cycle, with a maximum of 1 byte per cycle in COUNT/DATA/CHECK.
- imem_we is asserted exactly 1 cycle after the 4th byte of a word is accepted, and for exactly 1 cycle.
- Best-case word throughput is 5 cycles.
- imem_addr and imem_wdata are registered. They are stable during imem_we and hold their last value otherwise.
- Address wrap: when BASE_ADDR+index exceeds 2^ADDR_W-1, the address wraps to 0. A 256-word load with BASE_ADDR=0 writes addresses 0..255, each exactly once.
- core_hold falls in the same cycle load_done rises, which is 1 cycle after the final WRITE (macro off) or after checksum acceptance (macro on).
- start asserted in the same cycle as rst: rst wins.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined: the CHECK state exists. One trailing checksum byte (XOR of all 4N data bytes) is required, and a mismatch leads to ERROR.
- Undefined: no CHECK state, no XOR accumulator, and load_err is tied to 0. The loader goes WRITE -> DONE after the last word.

## Test plan
- Reset: assert rst for 2 cycles -> core_hold=1 and all other outputs 0. Then start, N=1, bytes 0x20 0x01 0x00 0x0A (plus checksum 0x2B with the macro on) -> single imem_we with imem_addr=0 and imem_wdata=0x2001000A. Then load_done=1 and core_hold=0.
- Back-pressure: deassert in_valid between every byte and hold in_valid high during WRITE -> no byte is lost or duplicated, and 3 words are written in order to addresses 0,1,2.
- Wrap: BASE_ADDR=250, N=10 -> writes to addresses 250..255 then 0..3.
- N=0 -> 256 writes, and load_done rises only after address 255.
- Macro on, wrong checksum (expected 0x2B, send 0x2C) -> load_err=1 and core_hold=1. A following start with a correct image -> load_done=1 and load_err=0.
- rst asserted after 2 bytes of word 1 -> IDLE with no further imem_we. start in DONE -> core_hold re-asserts on the next cycle.
